alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_pkg.sv | 116 +++++++++++
 rtl/alu_operand_stage_if.sv | 37 +++
 rtl/alu_operand_stage_regfile.sv | 40 ++++
 rtl/alu_operand_stage.sv | 135 +++++++++++++
 tb/tb_alu_operand_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared DLX/ALU definitions: word and opcode types, the 6-bit
//               ALU opcode constants, the I-type op constants, the
//               instruction field positions and the decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int C_XLEN = 32;

   typedef logic [C_XLEN-1:0] word_t;
   typedef logic [5:0]        opcode_t;
   typedef logic [4:0]        reg_idx_t;

   // Instruction field positions
   localparam int C_OP_MSB   = 31;
   localparam int C_OP_LSB   = 26;
   localparam int C_RS1_MSB  = 25;
   localparam int C_RS1_LSB  = 21;
   localparam int C_RS2_MSB  = 20;
   localparam int C_RS2_LSB  = 16;
   localparam int C_RD_MSB   = 15;
   localparam int C_RD_LSB   = 11;
   localparam int C_FUNC_MSB = 5;
   localparam int C_FUNC_LSB = 0;
   localparam int C_IMM_MSB  = 15;
   localparam int C_IMM_LSB  = 0;

   // ALU opcodes (equal to the R-type func field)
   localparam opcode_t C_ALU_SLL = 6'b000100;
   localparam opcode_t C_ALU_SRL = 6'b000110;
   localparam opcode_t C_ALU_SRA = 6'b000111;
   localparam opcode_t C_ALU_ADD = 6'b100000;
   localparam opcode_t C_ALU_SUB = 6'b100010;
   localparam opcode_t C_ALU_AND = 6'b100100;
   localparam opcode_t C_ALU_OR  = 6'b100101;
   localparam opcode_t C_ALU_XOR = 6'b100110;
   localparam opcode_t C_ALU_SEQ = 6'b101000;
   localparam opcode_t C_ALU_SNE = 6'b101001;
   localparam opcode_t C_ALU_SLT = 6'b101010;
   localparam opcode_t C_ALU_SGT = 6'b101011;
   localparam opcode_t C_ALU_SLE = 6'b101100;
   localparam opcode_t C_ALU_SGE = 6'b101101;

   // Major opcodes
   localparam opcode_t C_OP_RTYPE = 6'b000000;
   localparam opcode_t C_OP_ADDI  = 6'b001000;
   localparam opcode_t C_OP_SUBI  = 6'b001010;
   localparam opcode_t C_OP_ANDI  = 6'b001100;
   localparam opcode_t C_OP_ORI   = 6'b001101;
   localparam opcode_t C_OP_XORI  = 6'b001110;
   localparam opcode_t C_OP_SLLI  = 6'b010100;
   localparam opcode_t C_OP_SRLI  = 6'b010110;
   localparam opcode_t C_OP_SRAI  = 6'b010111;
   localparam opcode_t C_OP_SEQI  = 6'b011000;
   localparam opcode_t C_OP_SNEI  = 6'b011001;
   localparam opcode_t C_OP_SLTI  = 6'b011010;
   localparam opcode_t C_OP_SGTI  = 6'b011011;
   localparam opcode_t C_OP_SLEI  = 6'b011100;
   localparam opcode_t C_OP_SGEI  = 6'b011101;

   // Operand bundle held in the stage output register
   typedef struct packed {
      word_t    a;
      word_t    b;
      opcode_t  opcode;
      reg_idx_t rd;
   } operands_t;

   // Result of translating an I-type major opcode
   typedef struct packed {
      logic    legal;
      opcode_t alu_op;
   } imm_map_t;

   // True when the R-type func field names an operation the ALU implements
   function automatic logic is_alu_func(input opcode_t f);
      case (f)
         C_ALU_SLL, C_ALU_SRL, C_ALU_SRA,
         C_ALU_ADD, C_ALU_SUB,
         C_ALU_AND, C_ALU_OR,  C_ALU_XOR,
         C_ALU_SEQ, C_ALU_SNE, C_ALU_SLT,
         C_ALU_SGT, C_ALU_SLE, C_ALU_SGE: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   // Translates an I-type major opcode into its ALU opcode
   function automatic imm_map_t map_imm_op(input opcode_t op);
      imm_map_t m;
      m.legal  = 1'b1;
      m.alu_op = '0;
      case (op)
         C_OP_ADDI: m.alu_op = C_ALU_ADD;
         C_OP_SUBI: m.alu_op = C_ALU_SUB;
         C_OP_ANDI: m.alu_op = C_ALU_AND;
         C_OP_ORI:  m.alu_op = C_ALU_OR;
         C_OP_XORI: m.alu_op = C_ALU_XOR;
         C_OP_SLLI: m.alu_op = C_ALU_SLL;
         C_OP_SRLI: m.alu_op = C_ALU_SRL;
         C_OP_SRAI: m.alu_op = C_ALU_SRA;
         C_OP_SEQI: m.alu_op = C_ALU_SEQ;
         C_OP_SNEI: m.alu_op = C_ALU_SNE;
         C_OP_SLTI: m.alu_op = C_ALU_SLT;
         C_OP_SGTI: m.alu_op = C_ALU_SGT;
         C_OP_SLEI: m.alu_op = C_ALU_SLE;
         C_OP_SGEI: m.alu_op = C_ALU_SGE;
         default:   m.legal  = 1'b0;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Instruction-in / operands-out handshake, register-file
//               writeback port and illegal-instruction counter of the
//               operand stage. master = producer/consumer side, slave = stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if;
   import alu_pkg::*;

   logic     in_valid;
   logic     in_ready;
   word_t    in_instr;
   logic     out_valid;
   logic     out_ready;
   word_t    out_a;
   word_t    out_b;
   opcode_t  out_opcode;
   reg_idx_t out_rd;
   logic     wb_en;
   reg_idx_t wb_rd;
   word_t    wb_data;
   logic     [7:0] illegal_cnt;

   modport master (
      output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
      input  in_ready, out_valid, out_a, out_b, out_opcode, out_rd, illegal_cnt
   );

   modport slave (
      input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
      output in_ready, out_valid, out_a, out_b, out_opcode, out_rd, illegal_cnt
   );

endinterface
`default_nettype wire

// File: rtl/alu_operand_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile_32x32
// Description : 32 x 32-bit DLX register file, two combinational read ports,
//               one synchronous write port. r0 reads as zero and ignores
//               writes. Asynchronous active-high reset clears every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_32x32
   import alu_pkg::*;
(
   input  wire logic     clk,
   input  wire logic     rst,
   input  wire reg_idx_t rd_addr_a,
   output      word_t    rd_data_a,
   input  wire reg_idx_t rd_addr_b,
   output      word_t    rd_data_b,
   input  wire logic     wr_en,
   input  wire reg_idx_t wr_addr,
   input  wire word_t    wr_data
);

   word_t r_mem [32];

   // Register array: cleared on reset, written whenever writeback targets r1..r31
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_mem[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = (rd_addr_a == '0) ? '0 : r_mem[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0) ? '0 : r_mem[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : DLX operand-fetch stage. Decodes an instruction, reads the
//               register file (with writeback bypass) and holds the ALU
//               operands in a single valid/ready output register. Illegal
//               instructions are swallowed and counted (saturating at 255).
//               Build option: define IMM_EN to decode I-type instructions;
//               without it every non-R-type op is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
   import alu_pkg::*;
(
   input wire logic          clk,
   input wire logic          rst,
   alu_operand_stage_if.slave bus
);

   // Instruction fields
   opcode_t   w_op;
   opcode_t   w_func;
   reg_idx_t  w_rs1;
   reg_idx_t  w_rs2;
   reg_idx_t  w_rd;

   assign w_op   = bus.in_instr[C_OP_MSB:C_OP_LSB];
   assign w_rs1  = bus.in_instr[C_RS1_MSB:C_RS1_LSB];
   assign w_rs2  = bus.in_instr[C_RS2_MSB:C_RS2_LSB];
   assign w_rd   = bus.in_instr[C_RD_MSB:C_RD_LSB];
   assign w_func = bus.in_instr[C_FUNC_MSB:C_FUNC_LSB];

   // Shift-amount field is not used by this stage
   logic w_unused_shamt;
   assign w_unused_shamt = ^bus.in_instr[10:6];

   // Register file and writeback bypass
   word_t w_rf_a;
   word_t w_rf_b;
   word_t w_src_a;
   word_t w_src_b;

   regfile_32x32 u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (w_rs1),
      .rd_data_a (w_rf_a),
      .rd_addr_b (w_rs2),
      .rd_data_b (w_rf_b),
      .wr_en     (bus.wb_en),
      .wr_addr   (bus.wb_rd),
      .wr_data   (bus.wb_data)
   );

   // The regfile write lands at the end of this cycle, so a same-cycle
   // writeback to a source register must be forwarded around it.
   assign w_src_a = (bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == w_rs1)) ? bus.wb_data : w_rf_a;
   assign w_src_b = (bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == w_rs2)) ? bus.wb_data : w_rf_b;

`ifdef IMM_EN
   logic [15:0] w_imm;
   imm_map_t    w_imap;
   assign w_imm  = bus.in_instr[C_IMM_MSB:C_IMM_LSB];
   assign w_imap = map_imm_op(w_op);
`endif

   // Handshake and output register state
   logic      r_out_valid;
   operands_t r_out;
   logic      [7:0] r_illegal_cnt;
   logic      w_in_ready;
   logic      w_accept;
   logic      w_legal;
   operands_t w_next;

   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;

   // Decode: legality and the operand bundle the instruction would load
   always_comb begin
      w_legal = 1'b0;
      w_next  = '0;
      if (w_op == C_OP_RTYPE) begin
         w_legal       = is_alu_func(w_func);
         w_next.a      = w_src_a;
         w_next.b      = w_src_b;
         w_next.opcode = w_func;
         w_next.rd     = w_rd;
      end
`ifdef IMM_EN
      else if (w_imap.legal) begin
         w_legal       = 1'b1;
         w_next.a      = w_src_a;
         w_next.b      = {{16{w_imm[15]}}, w_imm};
         w_next.opcode = w_imap.alu_op;
         w_next.rd     = w_rs2;
      end
`endif
   end

   // Output register: refill on accept (illegal accepts leave it empty),
   // otherwise drain when downstream consumes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_accept) begin
         r_out_valid <= w_legal;
         if (w_legal) begin
            r_out <= w_next;
         end
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating count of accepted-but-illegal instructions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_illegal_cnt <= '0;
      end else if (w_accept && !w_legal && (r_illegal_cnt != 8'hFF)) begin
         r_illegal_cnt <= r_illegal_cnt + 8'd1;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_a       = r_out.a;
   assign bus.out_b       = r_out.b;
   assign bus.out_opcode  = r_out.opcode;
   assign bus.out_rd      = r_out.rd;
   assign bus.illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage. An independent
//               reference model predicts each accepted instruction into a
//               scoreboard queue; the head is compared while held.
//               Honours the IMM_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  opc;
      logic [4:0]  rd;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   exp_t        exp_q[$];
   logic [31:0] m_rf [32];
   int          m_ill;

   alu_operand_stage_if bus ();

   alu_operand_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input int rs1, input int rs2, input int rd, input logic [5:0] f);
      return {6'b000000, 5'(rs1), 5'(rs2), 5'(rd), 5'b00000, f};
   endfunction

   function automatic logic legal_func(input logic [5:0] f);
      case (f)
         6'h04, 6'h06, 6'h07, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [6:0] imm_opc(input logic [5:0] op);
      case (op)
         6'h08: return {1'b1, 6'h20};
         6'h0A: return {1'b1, 6'h22};
         6'h0C: return {1'b1, 6'h24};
         6'h0D: return {1'b1, 6'h25};
         6'h0E: return {1'b1, 6'h26};
         6'h14: return {1'b1, 6'h04};
         6'h16: return {1'b1, 6'h06};
         6'h17: return {1'b1, 6'h07};
         6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: return {1'b1, op + 6'h10};
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [31:0] src(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
      return m_rf[idx];
   endfunction

   task automatic predict(input logic [31:0] ins);
      exp_t       e;
      logic [6:0] im;
      im = imm_opc(ins[31:26]);
      if (ins[31:26] == 6'd0 && legal_func(ins[5:0])) begin
         e = '{a: src(ins[25:21]), b: src(ins[20:16]), opc: ins[5:0], rd: ins[15:11]};
         exp_q.push_back(e);
      end
`ifdef IMM_EN
      else if (im[6]) begin
         e = '{a: src(ins[25:21]), b: {{16{ins[15]}}, ins[15:0]}, opc: im[5:0], rd: ins[20:16]};
         exp_q.push_back(e);
      end
`endif
      else begin
         if (m_ill < 255) m_ill++;
      end
   endtask

   // One clock: inputs are already driven at the falling edge
   task automatic tick();
      logic exp_rdy;
      #1;
      exp_rdy = (exp_q.size() == 0) || bus.out_ready;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("out_a", bus.out_a, exp_q[0].a);
         chk("out_b", bus.out_b, exp_q[0].b);
         chk("out_opcode", 32'(bus.out_opcode), 32'(exp_q[0].opc));
         chk("out_rd", 32'(bus.out_rd), 32'(exp_q[0].rd));
      end
      chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_ill));
      if (bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (bus.in_valid && exp_rdy) predict(bus.in_instr);
      if (bus.wb_en && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_data;
      @(negedge clk);
   endtask

   task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wd);
      bus.in_valid  = v;
      bus.in_instr  = ins;
      bus.out_ready = ordy;
      bus.wb_en     = wen;
      bus.wb_rd     = wrd;
      bus.wb_data   = wd;
      tick();
   endtask

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_ill = 0;
   endtask

   initial begin
      logic [5:0] funcs [14];
      int         ill_before;
      funcs = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h22, 6'h24, 6'h25,
                6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D};
      total = 0;
      bad   = 0;
      model_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.out_ready = 1'b1;
      bus.wb_en     = 1'b0;
      bus.wb_rd     = 5'd0;
      bus.wb_data   = 32'h0;

      // Reset state
      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_a", bus.out_a, 32'd0);
      chk("rst_out_b", bus.out_b, 32'd0);
      chk("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
      chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
      chk("rst_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // R1=5, R2=1, then ADD r3,r1,r2
      step(0, 32'h0, 1, 1, 5'd1, 32'd5);
      step(0, 32'h0, 1, 1, 5'd2, 32'd1);
      step(1, rtype(1, 2, 3, 6'h20), 1, 0, 5'd0, 32'h0);
      #1;
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_a", bus.out_a, 32'd5);
      chk("add_b", bus.out_b, 32'd1);
      chk("add_opcode", 32'(bus.out_opcode), 32'h20);
      chk("add_rd", 32'(bus.out_rd), 32'd3);

      // Backpressure for 3 cycles with SUB r5,r1,r2 pending
      for (int i = 0; i < 3; i++) step(1, rtype(1, 2, 5, 6'h22), 0, 0, 5'd0, 32'h0);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_hold_a", bus.out_a, 32'd5);
      step(1, rtype(1, 2, 5, 6'h22), 1, 0, 5'd0, 32'h0);
      #1;
      chk("second_opcode", 32'(bus.out_opcode), 32'h22);
      chk("second_rd", 32'(bus.out_rd), 32'd5);
      step(0, 32'h0, 1, 0, 5'd0, 32'h0);

      // Bypass: writeback to R1 in the accept cycle of SUB r4,r1,r0
      step(1, rtype(1, 0, 4, 6'h22), 1, 1, 5'd1, 32'hDEAD_BEEF);
      #1;
      chk("bypass_a", bus.out_a, 32'hDEAD_BEEF);
      chk("bypass_b", bus.out_b, 32'h0);
      step(0, 32'h0, 1, 0, 5'd0, 32'h0);

      // Randomised traffic: all legal funcs, some illegal, stalls and bypasses
      for (int i = 0; i < 60; i++) begin
         logic [5:0] f;
         f = ($urandom_range(0, 5) == 0) ? 6'(($urandom_range(0, 7) * 9) + 1) : funcs[$urandom_range(0, 13)];
         step(1'($urandom_range(0, 3) != 0),
              {($urandom_range(0, 9) == 0) ? 6'b000001 : 6'b000000,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               5'($urandom), f},
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      step(0, 32'h0, 1, 0, 5'd0, 32'h0);
      step(0, 32'h0, 1, 0, 5'd0, 32'h0);

      // ADDI r2,r1,-1 with R1=7
      step(0, 32'h0, 1, 1, 5'd1, 32'd7);
      ill_before = m_ill;
      step(1, {6'b001000, 5'd1, 5'd2, 16'hFFFF}, 1, 0, 5'd0, 32'h0);
      #1;
`ifdef IMM_EN
      chk("addi_a", bus.out_a, 32'd7);
      chk("addi_b", bus.out_b, 32'hFFFF_FFFF);
      chk("addi_opcode", 32'(bus.out_opcode), 32'h20);
      chk("addi_rd", 32'(bus.out_rd), 32'd2);
`else
      chk("addi_illegal_cnt", 32'(bus.illegal_cnt), 32'(ill_before < 255 ? ill_before + 1 : 255));
      chk("addi_no_valid", 32'(bus.out_valid), 32'd0);
`endif
      step(0, 32'h0, 1, 0, 5'd0, 32'h0);

      // 300 illegal instructions: counter saturates, nothing becomes valid
      for (int i = 0; i < 300; i++) step(1, rtype(1, 2, 3, 6'h3F), 1, 0, 5'd0, 32'h0);
      #1;
      chk("sat_illegal_cnt", 32'(bus.illegal_cnt), 32'd255);
      chk("sat_out_valid", 32'(bus.out_valid), 32'd0);

      // Reset while an instruction is held
      step(0, 32'h0, 1, 1, 5'd1, 32'd9);
      step(1, rtype(1, 1, 3, 6'h20), 0, 0, 5'd0, 32'h0);
      #1;
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
      chk("midrst_out_a", bus.out_a, 32'd0);
      model_reset();
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1, rtype(1, 2, 7, 6'h20), 1, 0, 5'd0, 32'h0);
      #1;
      chk("post_rst_r1", bus.out_a, 32'd0);
      chk("post_rst_r2", bus.out_b, 32'd0);
      step(0, 32'h0, 1, 0, 5'd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
